// File: rtl/aes_inv_cipher_if.sv
// Request/response bundle for the iterative AES inverse cipher.
// NK sets the key width (32*NK bits); the block path is always 128 bits.
interface aes_inv_cipher_if #(
    parameter int NK = 4
);
    logic                 start;
    logic [32*NK-1:0]     key_in;
    logic [127:0]         cipher_in;
    logic                 busy;
    logic                 done;
    logic [127:0]         plain_out;

    modport master (
        output start, key_in, cipher_in,
        input  busy, done, plain_out
    );

    modport slave (
        input  start, key_in, cipher_in,
        output busy, done, plain_out
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per clock.
// The key is expanded forward into a round-key store, and the round keys are
// then consumed in reverse order. S-boxes are computed from the GF(2^8)
// inverse plus the affine map, so there are no lookup tables.
// Optional feature macro: AES_INV_KEY_CACHE_EN -- when the incoming key matches
// the last fully expanded key, key expansion is skipped.
package aes_inv_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // byte 0 in the MSBs, column-major: byte (row r, col c) = 4*c + r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction
endpackage

// One state column: InvSubBytes, AddRoundKey, then optional InvMixColumns.
module aes_inv_col (
    input  logic [31:0] col_in,
    input  logic [31:0] rk_col,
    input  logic        mix,
    output logic [31:0] col_out
);
    import aes_inv_pkg::*;

    logic [7:0]  t [4];
    logic [31:0] mixed;

    // substitute and add key per byte
    always_comb begin
        for (int r = 0; r < 4; r++)
            t[r] = inv_sbox(col_in[31-8*r -: 8]) ^ rk_col[31-8*r -: 8];
    end

    assign mixed = {
        gf_mul(8'h0e, t[0]) ^ gf_mul(8'h0b, t[1]) ^ gf_mul(8'h0d, t[2]) ^ gf_mul(8'h09, t[3]),
        gf_mul(8'h09, t[0]) ^ gf_mul(8'h0e, t[1]) ^ gf_mul(8'h0b, t[2]) ^ gf_mul(8'h0d, t[3]),
        gf_mul(8'h0d, t[0]) ^ gf_mul(8'h09, t[1]) ^ gf_mul(8'h0e, t[2]) ^ gf_mul(8'h0b, t[3]),
        gf_mul(8'h0b, t[0]) ^ gf_mul(8'h0d, t[1]) ^ gf_mul(8'h09, t[2]) ^ gf_mul(8'h0e, t[3])
    };

    assign col_out = mix ? mixed : {t[0], t[1], t[2], t[3]};
endmodule

module aes_inv_cipher #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              reset,
    aes_inv_cipher_if.slave   bus
);
    import aes_inv_pkg::*;

    localparam int NW = 4 * (NR + 1);

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_t;

    state_t       state, state_nxt;
    logic [31:0]  w [NW];
    logic [5:0]   idx;
    logic [2:0]   kpos;
    logic [7:0]   rcon;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] plain;
    logic         busy;
    logic         done;
    logic         cache_hit;

    logic [31:0]  prev, back, temp, kexp_word;
    logic [5:0]   rk_base;
    logic [127:0] rk, sh, lane_out;
    logic         mix_en;

`ifdef AES_INV_KEY_CACHE_EN
    logic             key_valid;
    logic [32*NK-1:0] cur_key;

    // w[0..NK-1] always holds the key that the store was expanded from
    always_comb begin
        cur_key = '0;
        for (int j = 0; j < NK; j++)
            cur_key[32*NK-1-32*j -: 32] = w[j];
    end
    assign cache_hit = key_valid && (bus.key_in == cur_key);
`else
    assign cache_hit = 1'b0;
`endif

    // next key-schedule word w[idx]
    always_comb begin
        prev = w[idx - 6'd1];
        back = w[idx - 6'(NK)];
        temp = prev;
        if (kpos == 3'd0)
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
        else if (NK == 8 && kpos == 3'd4)
            temp = sub_word(prev);
        kexp_word = back ^ temp;
    end

    // round key rk[rnd]; rnd is NR in INIT and reaches 0 in FINAL
    assign rk_base = {rnd, 2'b00};
    assign rk      = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    assign sh      = inv_shift_rows(st);
    assign mix_en  = (state == ROUND);

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_inv_col u_col (
            .col_in  (sh[127-32*c -: 32]),
            .rk_col  (rk[127-32*c -: 32]),
            .mix     (mix_en),
            .col_out (lane_out[127-32*c -: 32])
        );
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = cache_hit ? INIT : KEXP;
            KEXP:    if (idx == 6'(NW-1)) state_nxt = INIT;
            INIT:    state_nxt = ROUND;
            ROUND:   if (rnd == 4'd1) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // key schedule, round datapath and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            st    <= '0;
            plain <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            kpos  <= '0;
            rcon  <= 8'h01;
            rnd   <= '0;
            for (int j = 0; j < NW; j++) w[j] <= '0;
`ifdef AES_INV_KEY_CACHE_EN
            key_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    st   <= bus.cipher_in;
                    for (int j = 0; j < NK; j++)
                        w[j] <= bus.key_in[32*NK-1-32*j -: 32];
                    idx  <= 6'(NK);
                    kpos <= '0;
                    rcon <= 8'h01;
                    rnd  <= 4'(NR);
                    busy <= 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
                    // a miss rewrites the store, so the cache is stale until KEXP ends
                    if (!cache_hit) key_valid <= 1'b0;
`endif
                end
                KEXP: begin
                    w[idx] <= kexp_word;
                    idx    <= idx + 6'd1;
                    kpos   <= (kpos == 3'(NK-1)) ? 3'd0 : kpos + 3'd1;
                    if (kpos == 3'd0) rcon <= xtime(rcon);
`ifdef AES_INV_KEY_CACHE_EN
                    if (idx == 6'(NW-1)) key_valid <= 1'b1;
`endif
                end
                INIT: begin
                    st  <= st ^ rk;
                    rnd <= rnd - 4'd1;
                end
                ROUND: begin
                    st  <= lane_out;
                    rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    plain <= lane_out;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.plain_out = plain;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: AES-128 main instance plus one-shot
// AES-192 and AES-256 instances. Honours AES_INV_KEY_CACHE_EN when defined.
module tb_aes_inv_cipher;
`ifdef AES_INV_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_cipher_if #(.NK(4)) m ();
    aes_inv_cipher_if #(.NK(6)) m6 ();
    aes_inv_cipher_if #(.NK(8)) m8 ();

    aes_inv_cipher #(.NR(10), .NK(4)) u_dut    (.clk(clk), .reset(rst_n), .bus(m));
    aes_inv_cipher #(.NR(12), .NK(6)) u_dut192 (.clk(clk), .reset(rst_n), .bus(m6));
    aes_inv_cipher #(.NR(14), .NK(8)) u_dut256 (.clk(clk), .reset(rst_n), .bus(m8));

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_chk = 0;
    int           n_err = 0;
    bit           mdl_valid = 1'b0;
    logic [127:0] mdl_key = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // completions of the AES-128 instance are matched against the scoreboard
    always @(negedge clk) begin
        if (m.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 128'(1), 128'(0));
            end else begin
                mon_e = sb.pop_front();
                check("plain", m.plain_out, mon_e.pt);
                check("latency", 128'(cyc), 128'(mon_e.due));
            end
        end
    end

    // Starts a block at the current (negedge) time. glitch_k: offset of an
    // extra start pulse while busy; rst_k: offset at which reset aborts the run.
    task automatic run_blk(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input int glitch_k, input int rst_k);
        int lat, acc, nb, gk;
        bit hit, seen;
        hit = CACHE && mdl_valid && (key == mdl_key);
        if (!hit) mdl_valid = 1'b0;
        lat = hit ? 11 : 51;
        gk  = (glitch_k > 0 && glitch_k >= lat - 2) ? lat / 2 : glitch_k;
        m.start = 1'b1; m.key_in = key; m.cipher_in = ct;
        @(posedge clk); #1;
        acc = cyc;
        m.start = 1'b0;
        sb.push_back('{pt, acc + lat});
        nb = 0; seen = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (gk > 0 && k == gk) begin
                m.start = 1'b1; m.cipher_in = ~ct;
            end else begin
                m.start = 1'b0;
            end
            if (k == rst_k) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_busy", 128'(m.busy), 128'(0));
                check("rst_done", 128'(m.done), 128'(0));
                check("rst_plain", m.plain_out, 128'(0));
                rst_n = 1'b1;
                mdl_valid = 1'b0;
                void'(sb.pop_back());
                return;
            end
            if (m.done) begin
                seen = 1'b1;
                break;
            end
            if (m.busy) nb++;
        end
        check("done_seen", 128'(seen), 128'(1));
        check("busy_cycles", 128'(nb), 128'(lat));
        if (seen && !hit) begin
            mdl_valid = 1'b1;
            mdl_key = key;
        end
    endtask

    initial begin
        int acc;
        m.start = 1'b0;  m.key_in = '0;  m.cipher_in = '0;
        m6.start = 1'b0; m6.key_in = '0; m6.cipher_in = '0;
        m8.start = 1'b0; m8.key_in = '0; m8.cipher_in = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", 128'(m.busy), 128'(0));
        check("reset_done", 128'(m.done), 128'(0));
        check("reset_plain", m.plain_out, 128'(0));
        check("reset_plain192", m6.plain_out, 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_blk(K128, C128, PT, 0, 0);           // FIPS-197 C.1
        repeat (2) @(negedge clk);
        run_blk(K128, C128, PT, 20, 0);          // start while busy is ignored
        run_blk(K128, C128, PT, 0, 0);           // start on the done cycle
        repeat (2) @(negedge clk);
        run_blk(KB, CB, PB, 0, 0);               // FIPS-197 appendix B block
        repeat (2) @(negedge clk);
        run_blk(K128, C128, PT, 0, 30);          // reset aborts mid key expansion
        run_blk(K128, C128, PT, 0, 0);           // clean rerun after reset
        repeat (2) @(negedge clk);
        run_blk(K128, C128, PT, 0, 0);           // same key again (cache hit when enabled)
        repeat (2) @(negedge clk);
        run_blk(KB, CB, PB, 0, 0);               // key change restores full latency
        repeat (3) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'(0));

        // AES-192
        m6.start = 1'b1; m6.key_in = K192; m6.cipher_in = C192;
        @(posedge clk); #1;
        acc = cyc;
        m6.start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (m6.done) break;
        end
        check("plain192", m6.plain_out, PT);
        check("latency192", 128'(cyc - acc), 128'(59));

        // AES-256
        @(negedge clk);
        m8.start = 1'b1; m8.key_in = K256; m8.cipher_in = C256;
        @(posedge clk); #1;
        acc = cyc;
        m8.start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (m8.done) break;
        end
        check("plain256", m8.plain_out, PT);
        check("latency256", 128'(cyc - acc), 128'(67));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
